// File: rtl/program_loader_if.sv
// Bus bundle for program_loader: UART rx/tx byte handshakes, imem write port, status.
//   master : the loader (drives tx, imem write and status, samples rx and tx_ready)
//   slave  : the surrounding UART/imem/core side
interface program_loader_if #(
  parameter int unsigned ADDR_WIDTH = 15
) ();
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic [7:0]            tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  imem_we;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_wdata;
  logic                  loading;
  logic                  done;
  logic                  error;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output tx_data, tx_valid, imem_we, imem_addr, imem_wdata, loading, done, error
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  tx_data, tx_valid, imem_we, imem_addr, imem_wdata, loading, done, error
  );
endinterface

// File: rtl/program_loader.sv
// Boot-time program loader. Receives a 4-byte big-endian word count N from the
// UART, then N big-endian 32-bit words, writing word k to imem address k. After
// the last word (or immediately for N==0) sends ACK_BYTE and raises done.
// N larger than imem capacity parks the block in an error state.
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : program_loader_if.master (rx byte strobe in, tx byte out with
//              ready handshake, imem write port, loading/done/error status)
// All bus outputs are registered.
module program_loader #(
  parameter int unsigned ADDR_WIDTH = 15,
  parameter logic [7:0]  ACK_BYTE   = 8'hAA
) (
  input  logic             clk,
  input  logic             rst,
  program_loader_if.master bus
);

  localparam int unsigned CNT_W    = 33;
  localparam logic [CNT_W-1:0] CAPACITY = CNT_W'(1) << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_COUNT = 3'd0,
    S_WORD  = 3'd1,
    S_ACK   = 3'd2,
    S_DONE  = 3'd3,
    S_ERR   = 3'd4
  } state_t;

  state_t                state, state_n;
  logic [1:0]            byte_idx;
  logic [31:0]           count;
  logic [31:0]           word_sr;
  logic [ADDR_WIDTH-1:0] word_idx;

  logic [31:0]           count_nxt;
  logic [31:0]           word_nxt;
  logic                  count_last_byte;
  logic                  word_wr;
  logic                  word_last;

  logic                  we_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [31:0]           wdata_n;
  logic                  txv_n;
  logic                  loading_n;
  logic                  done_n;
  logic                  error_n;

  // Byte assembly helpers shared by next-state and output logic
  assign count_nxt       = {count[23:0], bus.rx_data};
  assign word_nxt        = {word_sr[23:0], bus.rx_data};
  assign count_last_byte = (state == S_COUNT) && bus.rx_valid && (byte_idx == 2'd3);
  assign word_wr         = (state == S_WORD) && bus.rx_valid && (byte_idx == 2'd3);
  assign word_last       = word_wr && ((32'(word_idx) + 32'd1) == count);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_COUNT;
      bus.imem_we    <= 1'b0;
      bus.imem_addr  <= '0;
      bus.imem_wdata <= '0;
      bus.tx_valid   <= 1'b0;
      bus.tx_data    <= ACK_BYTE;
      bus.loading    <= 1'b1;
      bus.done       <= 1'b0;
      bus.error      <= 1'b0;
    end else begin
      state          <= state_n;
      bus.imem_we    <= we_n;
      bus.imem_addr  <= addr_n;
      bus.imem_wdata <= wdata_n;
      bus.tx_valid   <= txv_n;
      bus.tx_data    <= ACK_BYTE;
      bus.loading    <= loading_n;
      bus.done       <= done_n;
      bus.error      <= error_n;
    end
  end

  // Next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      S_COUNT: begin
        if (count_last_byte) begin
          if (count_nxt == 32'd0) begin
            state_n = S_ACK;
          end else if (CNT_W'(count_nxt) > CAPACITY) begin
            state_n = S_ERR;
          end else begin
            state_n = S_WORD;
          end
        end
      end
      S_WORD: begin
        if (word_last) begin
          state_n = S_ACK;
        end
      end
      S_ACK: begin
        if (bus.tx_valid && bus.tx_ready) begin
          state_n = S_DONE;
        end
      end
      S_DONE:  state_n = S_DONE;
      S_ERR:   state_n = S_ERR;
      default: state_n = S_COUNT;
    endcase
  end

  // Output next values; address/data hold between writes
  always_comb begin
    we_n      = 1'b0;
    addr_n    = bus.imem_addr;
    wdata_n   = bus.imem_wdata;
    if (word_wr) begin
      we_n    = 1'b1;
      addr_n  = word_idx;
      wdata_n = word_nxt;
    end
    txv_n     = (state_n == S_ACK);
    loading_n = (state_n == S_COUNT) || (state_n == S_WORD) || (state_n == S_ACK);
    done_n    = (state_n == S_DONE);
    error_n   = (state_n == S_ERR);
  end

  // Byte/word counters and shift registers
  always_ff @(posedge clk) begin
    if (rst) begin
      byte_idx <= 2'd0;
      word_idx <= '0;
      count    <= 32'd0;
      word_sr  <= 32'd0;
    end else begin
      if (bus.rx_valid && (state == S_COUNT)) begin
        count    <= count_nxt;
        byte_idx <= byte_idx + 2'd1;
      end
      if (bus.rx_valid && (state == S_WORD)) begin
        word_sr  <= word_nxt;
        byte_idx <= byte_idx + 2'd1;
      end
      if (word_wr) begin
        word_idx <= word_idx + ADDR_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: byte-stream reference model plus
// directed scenarios and randomized loads.
module tb_program_loader;

  localparam int unsigned AW  = 4;
  localparam int unsigned CAP = 1 << AW;
  localparam logic [7:0]  ACK = 8'hAA;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  program_loader_if #(.ADDR_WIDTH(AW)) bus ();

  program_loader #(.ADDR_WIDTH(AW), .ACK_BYTE(ACK)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: everything follows from how many bytes of the current
  // load have been accepted and what they contained.
  int          nb;
  logic [31:0] mn, mw;
  bit          acked, started;
  logic          m_we, m_txv, m_load, m_done, m_err;
  logic [AW-1:0] m_addr;
  logic [31:0]   m_wdata;

  function automatic bit over_cap();
    return (nb >= 4) && (longint'(mn) > longint'(CAP));
  endfunction

  function automatic bit accepting();
    if (nb < 4) return 1'b1;
    if (over_cap()) return 1'b0;
    return longint'(nb) < 4 + 4 * longint'(mn);
  endfunction

  function automatic bit finished();
    return (nb >= 4) && !over_cap() && (longint'(nb) == 4 + 4 * longint'(mn));
  endfunction

  always @(posedge clk) begin
    started = 1'b1;
    if (rst) begin
      nb = 0; mn = 0; mw = 0; acked = 1'b0;
      m_we = 1'b0; m_addr = '0; m_wdata = '0; m_txv = 1'b0;
    end else begin
      if (m_txv && bus.tx_ready) acked = 1'b1;
      m_we = 1'b0;
      if (bus.rx_valid && accepting()) begin
        nb++;
        if (nb <= 4) begin
          mn = {mn[23:0], bus.rx_data};
        end else begin
          mw = {mw[23:0], bus.rx_data};
          if ((nb - 4) % 4 == 0) begin
            m_we    = 1'b1;
            m_addr  = AW'((nb - 4) / 4 - 1);
            m_wdata = mw;
          end
        end
      end
      m_txv = finished() && !acked;
    end
    m_err  = over_cap();
    m_done = acked;
    m_load = !m_err && !m_done;
  end

  // Write log and tx observation, plus per-cycle comparison against the model
  logic [AW-1:0] log_a[$];
  logic [31:0]   log_d[$];
  bit            tx_seen;

  always @(negedge clk) begin
    if (started) begin
      chk("imem_we",    bus.imem_we,    m_we);
      chk("imem_addr",  bus.imem_addr,  m_addr);
      chk("imem_wdata", bus.imem_wdata, m_wdata);
      chk("tx_valid",   bus.tx_valid,   m_txv);
      chk("tx_data",    bus.tx_data,    ACK);
      chk("loading",    bus.loading,    m_load);
      chk("done",       bus.done,       m_done);
      chk("error",      bus.error,      m_err);
      if (bus.imem_we) begin
        log_a.push_back(bus.imem_addr);
        log_d.push_back(bus.imem_wdata);
      end
      if (bus.tx_valid) tx_seen = 1'b1;
    end
  end

  // Stimulus helpers: inputs change 2 time units after each rising edge
  bit hold_rdy = 1'b0;

  task automatic step(input logic r, input logic v, input logic [7:0] d);
    rst          = r;
    bus.rx_valid = v;
    bus.rx_data  = d;
    bus.tx_ready = hold_rdy ? 1'b0 : ($urandom_range(0, 2) != 0);
    @(posedge clk);
    #2;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) step(1'b0, 1'b0, 8'($urandom));
    step(1'b0, 1'b1, b);
  endtask

  task automatic send_word(input logic [31:0] w, input bit b2b);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24], b2b ? 0 : (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0));
      t = t << 8;
    end
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    log_a.delete();
    log_d.delete();
    tx_seen = 1'b0;
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 100 && !bus.done; i++) step(1'b0, 1'b0, 8'h00);
    chk(name, bus.done, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] words[CAP];
  logic [31:0] n;
  int          r;
  int          abort_at;

  initial begin
    rst = 1'b1; bus.rx_valid = 1'b0; bus.rx_data = 8'h00; bus.tx_ready = 1'b0;
    do_reset();

    // Reset state
    chk("rst_loading", bus.loading,    1'b1);
    chk("rst_done",    bus.done,       1'b0);
    chk("rst_error",   bus.error,      1'b0);
    chk("rst_txv",     bus.tx_valid,   1'b0);
    chk("rst_txdata",  bus.tx_data,    8'hAA);
    chk("rst_we",      bus.imem_we,    1'b0);
    chk("rst_addr",    bus.imem_addr,  0);
    chk("rst_wdata",   bus.imem_wdata, 0);

    // Two-word program
    send_word(32'h0000_0002, 1'b0);
    send_word(32'h2021_0005, 1'b0);
    send_word(32'h0421_0001, 1'b0);
    wait_done("t1_done");
    chk("t1_nwr", log_a.size(), 2);
    if (log_a.size() == 2) begin
      chk("t1_a0", log_a[0], 0);
      chk("t1_d0", log_d[0], 32'h2021_0005);
      chk("t1_a1", log_a[1], 1);
      chk("t1_d1", log_d[1], 32'h0421_0001);
    end
    chk("t1_tx", tx_seen, 1'b1);
    chk("t1_loading", bus.loading, 1'b0);

    // Empty program
    do_reset();
    send_word(32'h0000_0000, 1'b0);
    wait_done("t2_done");
    chk("t2_nwr", log_a.size(), 0);
    chk("t2_tx", tx_seen, 1'b1);

    // Count one past capacity, followed by traffic that must be ignored
    do_reset();
    send_word(32'(CAP + 1), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 1'($urandom), 8'($urandom));
    chk("t3_error", bus.error, 1'b1);
    chk("t3_loading", bus.loading, 1'b0);
    chk("t3_done", bus.done, 1'b0);
    chk("t3_nwr", log_a.size(), 0);
    chk("t3_tx", tx_seen, 1'b0);

    // Three words, every byte on consecutive cycles
    do_reset();
    send_word(32'h0000_0003, 1'b1);
    send_word(32'h1111_2222, 1'b1);
    send_word(32'h3333_4444, 1'b1);
    send_word(32'h5555_6666, 1'b1);
    step(1'b0, 1'b0, 8'h00);
    chk("t4_nwr", log_a.size(), 3);
    if (log_a.size() == 3) begin
      chk("t4_a2", log_a[2], 2);
      chk("t4_d0", log_d[0], 32'h1111_2222);
      chk("t4_d2", log_d[2], 32'h5555_6666);
    end
    wait_done("t4_done");

    // Ack held off by tx_ready=0
    do_reset();
    hold_rdy = 1'b1;
    send_word(32'h0000_0000, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 8'h00);
    chk("t5_txv", bus.tx_valid, 1'b1);
    chk("t5_txdata", bus.tx_data, 8'hAA);
    chk("t5_done_early", bus.done, 1'b0);
    hold_rdy = 1'b0;
    wait_done("t5_done");

    // Reset in the middle of a load, then a fresh one-word load
    do_reset();
    send_word(32'h0000_0005, 1'b0);
    send_byte(8'hAB, 0);
    send_byte(8'hCD, 0);
    do_reset();
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    wait_done("t6_done");
    chk("t6_nwr", log_a.size(), 1);
    if (log_a.size() == 1) begin
      chk("t6_a0", log_a[0], 0);
      chk("t6_d0", log_d[0], 32'hDEAD_BEEF);
    end

    // Exactly full capacity
    do_reset();
    send_word(32'(CAP), 1'b0);
    for (int i = 0; i < CAP; i++) begin
      words[i] = $urandom;
      send_word(words[i], 1'b0);
    end
    wait_done("cap_done");
    chk("cap_nwr", log_a.size(), CAP);
    if (log_a.size() == CAP) begin
      chk("cap_alast", log_a[CAP-1], CAP - 1);
      chk("cap_dlast", log_d[CAP-1], words[CAP-1]);
    end

    // Randomized loads, occasionally aborted by reset
    for (int it = 0; it < 25; it++) begin
      do_reset();
      r = $urandom_range(0, 9);
      if (r < 2)       n = 32'd0;
      else if (r == 2) n = 32'(CAP);
      else if (r == 3) n = 32'(CAP + $urandom_range(1, 3));
      else if (r == 4) n = $urandom | 32'h8000_0000;
      else             n = 32'($urandom_range(1, CAP));
      abort_at = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 20) : -1;
      send_word(n, 1'($urandom));
      if (longint'(n) <= longint'(CAP)) begin
        for (int i = 0; i < int'(n) && abort_at != 0; i++) begin
          words[i] = $urandom;
          send_word(words[i], 1'($urandom));
          if (abort_at > 0) abort_at--;
        end
      end
      if (abort_at == 0) begin
        do_reset();
        chk("rnd_abort_loading", bus.loading, 1'b1);
      end else begin
        for (int i = 0; i < 20; i++) step(1'b0, 1'($urandom), 8'($urandom));
        if (longint'(n) <= longint'(CAP)) begin
          wait_done("rnd_done");
          chk("rnd_nwr", log_a.size(), n);
        end else begin
          chk("rnd_error", bus.error, 1'b1);
          chk("rnd_nwr_err", log_a.size(), 0);
        end
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
